// File: rtl/lampFPU_pkg.sv
// lampFPU_pkg
// Shared definitions for the LAMP 16-bit float (1 sign + 8 exponent + 7 fraction):
// field widths, rounding-mode encoding, infinity / max-finite {exp, frac}
// patterns and the round-up decision used by the rounding stage.
package lampFPU_pkg;

    localparam int LAMP_FLOAT_E_DW = 8;
    localparam int LAMP_FLOAT_F_DW = 7;
    localparam int LAMP_FLOAT_DW   = 1 + LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW;

    // {exponent, fraction} patterns, sign excluded
    localparam logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW-1:0] INF_E_F = 15'h7F80;
    localparam logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW-1:0] MAX_E_F = 15'h7F7F;

    typedef enum logic [1:0] {
        RND_RNE = 2'b00,   // nearest, ties to even
        RND_RTZ = 2'b01,   // toward zero
        RND_RUP = 2'b10,   // toward +inf
        RND_RDN = 2'b11    // toward -inf
    } rnd_mode_e;

    // Decide whether the kept significand is incremented by one ulp.
    function automatic logic FUNC_roundUpDecision(
        input logic      s,
        input logic      lsb,
        input logic      g,
        input logic      r,
        input logic      st,
        input rnd_mode_e mode
    );
        logic w_any;
        logic w_up;
        w_any = g | r | st;
        case (mode)
            RND_RNE: w_up = g & (lsb | r | st);
            RND_RTZ: w_up = 1'b0;
            RND_RUP: w_up = ~s & w_any;
            RND_RDN: w_up = s & w_any;
            default: w_up = 1'b0;
        endcase
        return w_up;
    endfunction

endpackage

// File: rtl/lampfpu_round_core.sv
// lampfpu_round_core
// Combinational rounding between the two pipeline registers: applies the
// precomputed increment, handles the mantissa carry-out, detects exponent
// overflow and chooses infinity or max-finite depending on rounding mode.
// Ports:
//   i_s, i_e (E_DW+1 bits, may already exceed the finite range), i_mant {hidden, frac}
//   i_up      increment decision, i_grs any discarded bit nonzero
//   i_round   0 = special value, pass {s, e, frac} through untouched
//   i_mode    rounding mode
//   o_res     packed {s, e, frac}; o_inexact, o_overflow flags
module lampfpu_round_core
    import lampFPU_pkg::*;
#(
    parameter int E_DW = LAMP_FLOAT_E_DW,
    parameter int F_DW = LAMP_FLOAT_F_DW
) (
    input  logic                 i_s,
    input  logic [E_DW:0]        i_e,
    input  logic [F_DW:0]        i_mant,
    input  logic                 i_up,
    input  logic                 i_grs,
    input  logic                 i_round,
    input  rnd_mode_e            i_mode,
    output logic [E_DW+F_DW:0]   o_res,
    output logic                 o_inexact,
    output logic                 o_overflow
);

    localparam logic [E_DW+1:0] E_INF_WIDE = {2'b00, {E_DW{1'b1}}};
    localparam logic [E_DW-1:0] E_ONES     = {E_DW{1'b1}};
    localparam logic [E_DW-1:0] E_MAX      = {{(E_DW-1){1'b1}}, 1'b0};

    logic [F_DW+1:0] w_sum;
    logic            w_carry;
    logic            w_unused_hidden;
    logic [F_DW-1:0] w_frac;
    logic [E_DW+1:0] w_e_fin;
    logic            w_ovf;
    logic            w_sat;

    assign w_sum           = {1'b0, i_mant} + {{(F_DW+1){1'b0}}, i_up};
    assign w_carry         = w_sum[F_DW+1];
    assign w_unused_hidden = w_sum[F_DW];
    // carry-out can only come from 1.111..1 + 1, so the fraction is zero
    assign w_frac          = w_carry ? {F_DW{1'b0}} : w_sum[F_DW-1:0];
    assign w_e_fin         = {1'b0, i_e} + {{(E_DW+1){1'b0}}, w_carry};
    assign w_ovf           = (w_e_fin >= E_INF_WIDE);
    // modes that never round away from zero in this sign direction saturate
    assign w_sat           = (i_mode == RND_RTZ) ||
                             ((i_mode == RND_RUP) && i_s) ||
                             ((i_mode == RND_RDN) && !i_s);

    // Select pass-through, overflow or normally rounded result.
    always_comb begin
        o_res      = {i_s, i_e[E_DW-1:0], i_mant[F_DW-1:0]};
        o_inexact  = 1'b0;
        o_overflow = 1'b0;
        if (!i_round) begin
            o_res      = {i_s, i_e[E_DW-1:0], i_mant[F_DW-1:0]};
            o_inexact  = 1'b0;
            o_overflow = 1'b0;
        end else if (w_ovf) begin
            o_res      = w_sat ? {i_s, E_MAX, {F_DW{1'b1}}} : {i_s, E_ONES, {F_DW{1'b0}}};
            o_inexact  = 1'b1;
            o_overflow = 1'b1;
        end else begin
            o_res      = {i_s, w_e_fin[E_DW-1:0], w_frac};
            o_inexact  = i_grs;
            o_overflow = 1'b0;
        end
    end

endmodule

// File: rtl/lampfpu_sqrt_round.sv
// lampfpu_sqrt_round
// Final stage after the square-root unit: post-normalises the extended
// significand, rounds it under the selected mode and packs the 16-bit LAMP
// float. Two registered stages with a valid/ready handshake, no skid buffer.
// Ports:
//   clk, rst (synchronous, active-high)
//   valid_i/ready_o     input handshake
//   s_i, e_i, f_i       sign, biased exponent, {carry, hidden, frac, G, R, S}
//   isToRound_i         0 = special value, pass through unrounded
//   rndMode_i           00 RNE, 01 RTZ, 10 RUP, 11 RDN
//   valid_o/ready_i     output handshake
//   res_o, inexact_o, overflow_o   registered result and flags
module lampfpu_sqrt_round
    import lampFPU_pkg::*;
#(
    parameter int E_DW = LAMP_FLOAT_E_DW,
    parameter int F_DW = LAMP_FLOAT_F_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               s_i,
    input  logic [E_DW-1:0]    e_i,
    input  logic [F_DW+4:0]    f_i,
    input  logic               isToRound_i,
    input  logic [1:0]         rndMode_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [E_DW+F_DW:0] res_o,
    output logic               inexact_o,
    output logic               overflow_o
);

    // stage 1
    logic            r_s1_valid;
    logic            r_s1_s;
    logic [E_DW:0]   r_s1_e;
    logic [F_DW:0]   r_s1_mant;
    logic            r_s1_up;
    logic            r_s1_grs;
    logic            r_s1_round;
    rnd_mode_e       r_s1_mode;
    // stage 2
    logic            r_s2_valid;
    logic [E_DW+F_DW:0] r_res;
    logic            r_inexact;
    logic            r_overflow;

    logic            w_adv2;
    rnd_mode_e       w_mode;
    logic [F_DW+3:0] w_f_norm;   // {hidden, frac, G, R, S}
    logic [E_DW:0]   w_e_norm;
    logic            w_up;
    logic            w_grs;
    logic [E_DW+F_DW:0] w_res;
    logic            w_inexact;
    logic            w_overflow;

    assign w_adv2  = !r_s2_valid || ready_i;
    assign ready_o = !r_s1_valid || w_adv2;
    assign w_mode  = rnd_mode_e'(rndMode_i);

    // Pre-normalise: a set carry bit shifts right once, folding the dropped bit into sticky.
    always_comb begin
        w_f_norm = f_i[F_DW+3:0];
        w_e_norm = {1'b0, e_i};
        if (f_i[F_DW+4]) begin
            w_f_norm = {f_i[F_DW+4:2], f_i[1] | f_i[0]};
            w_e_norm = {1'b0, e_i} + {{E_DW{1'b0}}, 1'b1};
        end else begin
            w_f_norm = f_i[F_DW+3:0];
            w_e_norm = {1'b0, e_i};
        end
    end

    assign w_up  = isToRound_i &
                   FUNC_roundUpDecision(s_i, w_f_norm[3], w_f_norm[2], w_f_norm[1], w_f_norm[0], w_mode);
    assign w_grs = isToRound_i & (|w_f_norm[2:0]);

    lampfpu_round_core #(
        .E_DW (E_DW),
        .F_DW (F_DW)
    ) u_round_core (
        .i_s        (r_s1_s),
        .i_e        (r_s1_e),
        .i_mant     (r_s1_mant),
        .i_up       (r_s1_up),
        .i_grs      (r_s1_grs),
        .i_round    (r_s1_round),
        .i_mode     (r_s1_mode),
        .o_res      (w_res),
        .o_inexact  (w_inexact),
        .o_overflow (w_overflow)
    );

    // Two-stage pipeline: each stage loads only when the stage after it can move.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_s     <= 1'b0;
            r_s1_e     <= {(E_DW+1){1'b0}};
            r_s1_mant  <= {(F_DW+1){1'b0}};
            r_s1_up    <= 1'b0;
            r_s1_grs   <= 1'b0;
            r_s1_round <= 1'b0;
            r_s1_mode  <= RND_RNE;
            r_s2_valid <= 1'b0;
            r_res      <= {(E_DW+F_DW+1){1'b0}};
            r_inexact  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (ready_o) begin
                r_s1_valid <= valid_i;
                if (valid_i) begin
                    r_s1_s     <= s_i;
                    // specials keep their raw exponent and fraction
                    r_s1_e     <= isToRound_i ? w_e_norm : {1'b0, e_i};
                    r_s1_mant  <= isToRound_i ? w_f_norm[F_DW+3:3] : f_i[F_DW+3:3];
                    r_s1_up    <= w_up;
                    r_s1_grs   <= w_grs;
                    r_s1_round <= isToRound_i;
                    r_s1_mode  <= w_mode;
                end
            end
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_res      <= w_res;
                    r_inexact  <= w_inexact;
                    r_overflow <= w_overflow;
                end
            end
        end
    end

    assign valid_o    = r_s2_valid;
    assign res_o      = r_res;
    assign inexact_o  = r_inexact;
    assign overflow_o = r_overflow;

endmodule
